// File: rtl/fpadd_issue.sv
// ---------------------------------------------------------------------------
// fpadd_issue
//
// Operand-issue and result-capture controller placed in front of fpadd.
// Operand pairs are queued in a small FIFO and handed to the adder one at a
// time using its start/done return-to-zero handshake. Each sum is captured
// into a single-entry output register with a valid/ready handshake.
//
// Parameters:
//   DEPTH    operand FIFO entries (power of 2, >= 2)
//   TIMEOUT  watchdog limit in cycles (only with FPADD_ISSUE_TIMEOUT_EN)
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand push handshake; in_a, in_b operands
//   out_valid/out_ready   result handshake; out_sum result, out_err timeout flag
//   add_start, add_a/b    issue side towards fpadd
//   add_sum, add_done     completion side from fpadd
//   busy                  controller is not idle
//   count                 FIFO occupancy
//
// Build option:
//   FPADD_ISSUE_TIMEOUT_EN  enables the ISSUE/RELEASE watchdog; when it fires
//                           in ISSUE a quiet NaN is returned with out_err=1.
//                           Without it the FSM waits indefinitely and out_err
//                           is constant 0.
// ---------------------------------------------------------------------------
module fpadd_issue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_a,
    input  logic [31:0]            in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_sum,
    output logic                   out_err,
    output logic                   add_start,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    input  logic [31:0]            add_sum,
    input  logic                   add_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state_q;
    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          add_start_q;
    logic [31:0]   add_a_q, add_b_q;
    logic [31:0]   out_sum_q;
    logic          out_valid_q;
    logic          push, pop, start_issue, timeout_hit;
    logic [63:0]   head;

`ifdef FPADD_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q;
    logic          out_err_q;

    // Timer counts cycles since entering ISSUE/RELEASE; firing one cycle
    // before it would reach TIMEOUT makes the exit land exactly TIMEOUT
    // cycles after entry.
    assign timeout_hit = (state_q != IDLE) && (timer_q == TW'(TIMEOUT - 1));
    assign out_err     = out_err_q;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
    assign out_err        = 1'b0;
`endif

    // in_ready uses the registered count, so a full FIFO never accepts a
    // push even when a pop happens in the same cycle.
    assign in_ready    = (count_q < CW'(DEPTH));
    assign push        = in_valid & in_ready;
    assign start_issue = (state_q == IDLE) && (count_q != '0) && !out_valid_q;
    // The head entry leaves the FIFO only when the adder is released.
    assign pop         = (state_q == ISSUE) && (add_done || timeout_hit);
    assign head        = mem_q[rd_ptr_q];

    assign add_start = add_start_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign out_sum   = out_sum_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // Storage carries no reset: stale entries are unreachable once the
    // pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            add_start_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef FPADD_ISSUE_TIMEOUT_EN
            out_err_q   <= 1'b0;
            timer_q     <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;

            if (out_valid_q && out_ready) out_valid_q <= 1'b0;

`ifdef FPADD_ISSUE_TIMEOUT_EN
            if (start_issue || pop)  timer_q <= '0;
            else if (state_q != IDLE) timer_q <= timer_q + 1'b1;
`endif

            unique case (state_q)
                IDLE: begin
                    // out_valid gating guarantees a capture never
                    // overwrites an unread result.
                    if (start_issue) begin
                        add_a_q     <= head[63:32];
                        add_b_q     <= head[31:0];
                        add_start_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (add_done) begin
                        out_sum_q   <= add_sum;
                        out_valid_q <= 1'b1;
`ifdef FPADD_ISSUE_TIMEOUT_EN
                        out_err_q   <= 1'b0;
`endif
                        add_start_q <= 1'b0;
                        state_q     <= RELEASE;
                    end
`ifdef FPADD_ISSUE_TIMEOUT_EN
                    else if (timeout_hit) begin
                        out_sum_q   <= 32'h7FC0_0000;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b1;
                        add_start_q <= 1'b0;
                        state_q     <= RELEASE;
                    end
`endif
                end
                RELEASE: begin
                    // Wait for fpadd to return done to zero before the
                    // next pair may be issued.
                    if (!add_done || timeout_hit) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_issue.sv
`timescale 1ns/1ps
module tb_fpadd_issue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_err;
    logic        add_start;
    logic [31:0] add_a, add_b;
    logic [31:0] add_sum;
    logic        add_done;
    logic        busy;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    fpadd_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_done  (add_done),
        .busy      (busy),
        .count     (count)
    );

    // ---------------- fpadd behavioural model ----------------
    // Known sums for the pairs used below (hand-computed IEEE-754 values).
    function automatic logic [31:0] fp_lut(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] k;
        k = {a, b};
        case (k)
            64'h3F800000_40000000: return 32'h40400000; // 1 + 2
            64'h3F800000_3F800000: return 32'h40000000; // 1 + 1
            64'h40000000_40000000: return 32'h40800000; // 2 + 2
            64'hBF800000_3F800000: return 32'h00000000; // -1 + 1
            64'h40400000_BF800000: return 32'h40000000; // 3 + -1
            64'h40800000_40800000: return 32'h41000000; // 4 + 4
            default:               return a ^ b;
        endcase
    endfunction

    int          m_dly   = 5;
    int          m_hold  = 0;
    bit          m_never = 1'b0;
    logic        m_done  = 1'b0;
    logic [31:0] m_sum   = 32'h0;
    int          m_cnt   = 0;
    int          m_hcnt  = 0;
    logic        force_done;

    always @(posedge clk) begin
        if (add_start) begin
            m_hcnt <= m_hold;
            if (!m_done && !m_never) begin
                if (m_cnt + 1 >= m_dly) begin
                    m_done <= 1'b1;
                    m_sum  <= fp_lut(add_a, add_b);
                end
                m_cnt <= m_cnt + 1;
            end
        end else begin
            m_cnt <= 0;
            if (m_done) begin
                if (m_hcnt > 0) m_hcnt <= m_hcnt - 1;
                else            m_done <= 1'b0;
            end
        end
    end

    assign add_done = m_done | force_done;
    assign add_sum  = m_sum;

    // Count rising edges of add_start.
    int   issue_cnt  = 0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (add_start && !prev_start) issue_cnt <= issue_cnt + 1;
        prev_start <= add_start;
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    vec_t tv [5];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    // with in_valid still high.
    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("push in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_result(input string name, input logic [31:0] exp, input logic exp_err);
        int w;
        w = 0;
        while (out_valid !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check({name, " sum"}, out_sum, exp);
        check({name, " err"}, 32'(out_err), 32'(exp_err));
        $display("result %s: sum=%h err=%b", name, out_sum, out_err);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   base;
        logic seen;

        tv[0] = '{32'h3F800000, 32'h3F800000, 32'h40000000};
        tv[1] = '{32'h40000000, 32'h40000000, 32'h40800000};
        tv[2] = '{32'hBF800000, 32'h3F800000, 32'h00000000};
        tv[3] = '{32'h40400000, 32'hBF800000, 32'h40000000};
        tv[4] = '{32'h40800000, 32'h40800000, 32'h41000000};

        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0; force_done = 1'b0;

        // ---- reset state ----
        #2;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst add_start", 32'(add_start), 32'd0);
        check("rst count", 32'(count), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_sum", out_sum, 32'd0);
        check("rst add_a", add_a, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // ---- first pair: issue latency and capture timing ----
        out_ready = 1'b1;
        push_pair(32'h3F800000, 32'h40000000);
        in_valid = 1'b0;
        check("t1 start after push edge", 32'(add_start), 32'd0);
        check("t1 count after push", 32'(count), 32'd1);
        @(negedge clk);
        check("t1 start two edges after push", 32'(add_start), 32'd1);
        check("t1 busy", 32'(busy), 32'd1);
        check("t1 add_a", add_a, 32'h3F800000);
        check("t1 add_b", add_b, 32'h40000000);
        w = 0;
        while (add_done !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        check("t1 done seen", 32'(add_done), 32'd1);
        @(negedge clk);
        check("t1 out_valid", 32'(out_valid), 32'd1);
        check("t1 out_sum", out_sum, 32'h40400000);
        check("t1 out_err", 32'(out_err), 32'd0);
        check("t1 start dropped", 32'(add_start), 32'd0);
        @(negedge clk);
        check("t1 consumed", 32'(out_valid), 32'd0);
        repeat (5) @(negedge clk);

        // ---- table vectors one at a time ----
        for (int i = 0; i < 5; i++) begin
            push_pair(tv[i].a, tv[i].b);
            in_valid = 1'b0;
            wait_result($sformatf("vec%0d", i), tv[i].sum, 1'b0);
        end
        repeat (5) @(negedge clk);

        // ---- fill FIFO with out_ready low ----
        out_ready = 1'b0;
        base = issue_cnt;
        for (int i = 0; i < 4; i++) push_pair(tv[i].a, tv[i].b);
        check("fill count=4", 32'(count), 32'd4);
        check("fill in_ready low", 32'(in_ready), 32'd0);
        push_pair(tv[4].a, tv[4].b);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("fill count after 5th", 32'(count), 32'd4);
        check("fill out_valid held", 32'(out_valid), 32'd1);
        check("fill first sum", out_sum, tv[0].sum);
        check("fill start idle", 32'(add_start), 32'd0);
        check("fill one issue", 32'(issue_cnt - base), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) wait_result($sformatf("drain%0d", i), tv[i].sum, 1'b0);
        repeat (5) @(negedge clk);

        // ---- done held high after start drops ----
        m_hold = 3;
        push_pair(tv[0].a, tv[0].b);
        push_pair(tv[1].a, tv[1].b);
        in_valid = 1'b0;
        wait_result("hold0", tv[0].sum, 1'b0);
        w = 0;
        while (add_done !== 1'b0 && w < 50) begin @(negedge clk); w++; end
        check("hold done fell", 32'(add_done), 32'd0);
        check("hold start at fall", 32'(add_start), 32'd0);
        @(negedge clk);
        check("hold start fall+1", 32'(add_start), 32'd0);
        @(negedge clk);
        check("hold start fall+2", 32'(add_start), 32'd1);
        wait_result("hold1", tv[1].sum, 1'b0);
        m_hold = 0;
        repeat (10) @(negedge clk);

        // ---- simultaneous push and pop at count=2 ----
        push_pair(tv[2].a, tv[2].b);
        push_pair(tv[3].a, tv[3].b);
        in_valid = 1'b0;
        w = 0;
        while (!(add_start === 1'b1 && add_done === 1'b1) && w < 50) begin @(negedge clk); w++; end
        check("pp count before", 32'(count), 32'd2);
        in_a = tv[4].a; in_b = tv[4].b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("pp count after", 32'(count), 32'd2);
        wait_result("pp0", tv[2].sum, 1'b0);
        wait_result("pp1", tv[3].sum, 1'b0);
        wait_result("pp2", tv[4].sum, 1'b0);
        repeat (5) @(negedge clk);

        // ---- reset in the middle of ISSUE ----
        push_pair(tv[0].a, tv[0].b);
        push_pair(tv[1].a, tv[1].b);
        push_pair(tv[2].a, tv[2].b);
        in_valid = 1'b0;
        check("mid pre start", 32'(add_start), 32'd1);
        check("mid pre count", 32'(count), 32'd3);
        reset = 1'b0;
        #1;
        check("mid rst add_start", 32'(add_start), 32'd0);
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst count", 32'(count), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        base = issue_cnt;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("mid no result", 32'(seen), 32'd0);
        check("mid no issue", 32'(issue_cnt - base), 32'd0);

        // ---- done while idle is ignored ----
        force_done = 1'b1;
        repeat (3) @(negedge clk);
        check("idle done out_valid", 32'(out_valid), 32'd0);
        check("idle done busy", 32'(busy), 32'd0);
        force_done = 1'b0;
        repeat (3) @(negedge clk);

`ifdef FPADD_ISSUE_TIMEOUT_EN
        // ---- watchdog ----
        m_never = 1'b1;
        push_pair(tv[0].a, tv[0].b);
        in_valid = 1'b0;
        @(negedge clk);
        check("to start", 32'(add_start), 32'd1);
        repeat (15) @(negedge clk);
        check("to not yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("to valid", 32'(out_valid), 32'd1);
        check("to sum", out_sum, 32'h7FC00000);
        check("to err", 32'(out_err), 32'd1);
        m_never = 1'b0;
        repeat (5) @(negedge clk);
        push_pair(tv[1].a, tv[1].b);
        in_valid = 1'b0;
        wait_result("to next", tv[1].sum, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
